// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC controller and the ADC/DAC models.
// Holds the controller state encoding and the default resolution.
package adc_pkg;

   localparam int ADC_NBITS = 12;
   localparam int ADC_SAMPLE_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAMPLE  = 2'd1,
      CONVERT = 2'd2,
      VALID   = 2'd3
   } adc_state_t;

endpackage

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample/hold, binary search over
// DAC_CODE driven by CMP, and a valid/ready result port with overrun flag.
module sar_adc_ctrl
   import adc_pkg::*;
#(
   parameter int NBITS = ADC_NBITS,
   parameter int SAMPLE_CYCLES = ADC_SAMPLE_CYCLES
) (
   input  logic             CK,
   input  logic             RSTN,
   input  logic             START,
   input  logic             CMP,
   output logic             SH,
   output logic [NBITS-1:0] DAC_CODE,
   output logic             BUSY,
   output logic [NBITS-1:0] DOUT,
   output logic             DOUT_VALID,
   input  logic             DOUT_READY,
   output logic             OVR
);

   localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [3:0] SLOAD = 4'(SAMPLE_CYCLES - 1);
   localparam logic [BW-1:0] BTOP = BW'(NBITS - 1);
   localparam logic [NBITS-1:0] ONE = NBITS'(1);
   localparam logic [NBITS-1:0] MSB = ONE << (NBITS - 1);

   adc_state_t state_q, state_d;
   logic [3:0] scnt_q, scnt_d;
   logic [BW-1:0] bidx_q, bidx_d;
   logic [NBITS-1:0] dac_q, dac_d;
   logic [NBITS-1:0] dout_q, dout_d;
   logic ovr_q, ovr_d;

   logic [NBITS-1:0] mask;
   logic [NBITS-1:0] trial;

   // Resolve the current bit and seed the next one; nothing below bit 0.
   assign mask = ONE << bidx_q;
   assign trial = (CMP ? dac_q : (dac_q & ~mask)) | (mask >> 1);

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         scnt_q  <= '0;
         bidx_q  <= '0;
         dac_q   <= '0;
         dout_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bidx_q  <= bidx_d;
         dac_q   <= dac_d;
         dout_q  <= dout_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      bidx_d  = bidx_q;
      dac_d   = dac_q;
      dout_d  = dout_q;
      ovr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               state_d = SAMPLE;
               scnt_d  = SLOAD;
            end
         end
         SAMPLE: begin
            ovr_d = START;
            if (scnt_q == 4'd0) begin
               state_d = CONVERT;
               dac_d   = MSB;
               bidx_d  = BTOP;
            end else begin
               scnt_d = scnt_q - 4'd1;
            end
         end
         CONVERT: begin
            ovr_d = START;
            dac_d = trial;
            if (bidx_q == '0) begin
               dout_d  = trial;
               state_d = VALID;
            end else begin
               bidx_d = bidx_q - BW'(1);
            end
         end
         VALID: begin
            if (DOUT_READY) begin
               if (START) begin
                  state_d = SAMPLE;
                  scnt_d  = SLOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               ovr_d = START;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign SH         = (state_q == SAMPLE);
   assign BUSY       = (state_q == SAMPLE) || (state_q == CONVERT);
   assign DOUT_VALID = (state_q == VALID);
   assign DAC_CODE   = dac_q;
   assign DOUT       = dout_q;
   assign OVR        = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl at default parameters (12 bits, 2 sample
// cycles) with a behavioral comparator.
module tb_sar_adc_ctrl;

   logic CK;
   logic RSTN;
   logic START;
   logic CMP;
   logic SH;
   logic [11:0] DAC_CODE;
   logic BUSY;
   logic [11:0] DOUT;
   logic DOUT_VALID;
   logic DOUT_READY;
   logic OVR;

   int mode;
   logic [11:0] tgt;
   int total;
   int bad;

   sar_adc_ctrl dut (
      .CK(CK),
      .RSTN(RSTN),
      .START(START),
      .CMP(CMP),
      .SH(SH),
      .DAC_CODE(DAC_CODE),
      .BUSY(BUSY),
      .DOUT(DOUT),
      .DOUT_VALID(DOUT_VALID),
      .DOUT_READY(DOUT_READY),
      .OVR(OVR)
   );

   // mode 0: analog level tgt, 1: CMP tied high, 2: CMP tied low
   assign CMP = (mode == 1) ? 1'b1 :
                (mode == 2) ? 1'b0 :
                (tgt >= DAC_CODE);

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rstchk(input string tag);
      chk({tag, ".sh"}, 32'(SH), 0);
      chk({tag, ".dac"}, 32'(DAC_CODE), 0);
      chk({tag, ".dout"}, 32'(DOUT), 0);
      chk({tag, ".dv"}, 32'(DOUT_VALID), 0);
      chk({tag, ".busy"}, 32'(BUSY), 0);
      chk({tag, ".ovr"}, 32'(OVR), 0);
   endtask

   task automatic drain(input string tag, input logic [11:0] ex);
      DOUT_READY = 1'b1;
      tick();
      DOUT_READY = 1'b0;
      chk({tag, ".dv"}, 32'(DOUT_VALID), 0);
      chk({tag, ".busy"}, 32'(BUSY), 0);
      chk({tag, ".sh"}, 32'(SH), 0);
      chk({tag, ".dout"}, 32'(DOUT), 32'(ex));
      chk({tag, ".dac"}, 32'(DAC_CODE), 32'(ex));
   endtask

   task automatic run(input int m, input logic [11:0] t,
                      input logic [11:0] ex, input bit b2b,
                      input int ovr_at, input string tag);
      int shc;
      int v;
      mode = m;
      tgt = t;
      START = 1'b1;
      DOUT_READY = b2b;
      tick();
      START = 1'b0;
      DOUT_READY = 1'b0;
      chk({tag, ".sh0"}, 32'(SH), 1);
      chk({tag, ".busy0"}, 32'(BUSY), 1);
      chk({tag, ".dv0"}, 32'(DOUT_VALID), 0);
      shc = int'(SH);
      for (int e = 1; e <= 14; e++) begin
         if (e == ovr_at) START = 1'b1;
         tick();
         START = 1'b0;
         if (e == ovr_at) chk({tag, ".ovr"}, 32'(OVR), 1);
         if (e == ovr_at + 1) chk({tag, ".ovr_end"}, 32'(OVR), 0);
         if (e <= 13) shc += int'(SH);
         if (e >= 2 && e <= 13 && m == 1) begin
            v = ((1 << (e - 1)) - 1) << (13 - e);
            chk({tag, ".dac_seq"}, 32'(DAC_CODE), 32'(v));
         end
         if (e >= 2 && e <= 13 && m == 2) begin
            v = 1 << (13 - e);
            chk({tag, ".dac_seq"}, 32'(DAC_CODE), 32'(v));
         end
         if (e == 13) chk({tag, ".dv_early"}, 32'(DOUT_VALID), 0);
      end
      chk({tag, ".dv"}, 32'(DOUT_VALID), 1);
      chk({tag, ".dout"}, 32'(DOUT), 32'(ex));
      chk({tag, ".dac_final"}, 32'(DAC_CODE), 32'(ex));
      chk({tag, ".busy"}, 32'(BUSY), 0);
      chk({tag, ".sh"}, 32'(SH), 0);
      chk({tag, ".sh_cycles"}, 32'(shc), 2);
   endtask

   initial begin
      total = 0;
      bad = 0;
      mode = 0;
      tgt = '0;
      START = 1'b0;
      DOUT_READY = 1'b0;
      RSTN = 1'b1;
      #2;
      RSTN = 1'b0;
      #1;
      rstchk("reset");
      tick();
      tick();
      RSTN = 1'b1;
      tick();
      rstchk("idle");

      run(0, 12'h9A5, 12'h9A5, 1'b0, 5, "conv9a5");
      drain("drain9a5", 12'h9A5);

      run(2, 12'h000, 12'h000, 1'b0, 0, "tied0");
      drain("drain0", 12'h000);

      run(1, 12'h000, 12'hFFF, 1'b0, 0, "tied1");
      drain("drainfff", 12'hFFF);

      DOUT_READY = 1'b1;
      tick();
      DOUT_READY = 1'b0;
      chk("ready_idle.busy", 32'(BUSY), 0);
      chk("ready_idle.dv", 32'(DOUT_VALID), 0);

      run(0, 12'h5A3, 12'h5A3, 1'b0, 0, "conv5a3");
      for (int c = 0; c < 20; c++) begin
         if (c == 3 || c == 10) START = 1'b1;
         tick();
         START = 1'b0;
         chk("hold.dout", 32'(DOUT), 32'h5A3);
         chk("hold.dv", 32'(DOUT_VALID), 1);
         chk("hold.busy", 32'(BUSY), 0);
         chk("hold.ovr", 32'(OVR), (c == 3 || c == 10) ? 1 : 0);
      end

      run(0, 12'h123, 12'h123, 1'b1, 0, "b2b123");
      drain("drain123", 12'h123);

      mode = 0;
      tgt = 12'hABC;
      START = 1'b1;
      tick();
      START = 1'b0;
      repeat (8) tick();
      chk("mid.busy", 32'(BUSY), 1);
      chk("mid.dac", 32'(DAC_CODE), 32'hAA0);
      RSTN = 1'b0;
      #1;
      rstchk("abort");
      #2;
      RSTN = 1'b1;

      run(0, 12'h800, 12'h800, 1'b0, 0, "conv800");
      drain("drain800", 12'h800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter NBITS, default 12: conversion resolution in bits.
REQ-002 Parameter SAMPLE_CYCLES, default 2, range 1..15: number of CK cycles SH is held high.
REQ-003 Port CK, input, 1: the only clock; all state updates on the rising edge.
REQ-004 Port RSTN, input, 1: reset, asynchronous and active-low.
REQ-005 Port START, input, 1: conversion request, sampled on the rising edge of CK.
REQ-006 Port CMP, input, 1: comparator result; 1 means analog input >= DAC output for the current DAC_CODE.
REQ-007 Port SH, output, 1: sample/hold control; 1 = track, 0 = hold.
REQ-008 Port DAC_CODE, output, NBITS: trial code driven to the DAC.
REQ-009 Port BUSY, output, 1: high in the SAMPLE and CONVERT states.
REQ-010 Port DOUT, output, NBITS: conversion result, valid when DOUT_VALID=1.
REQ-011 Port DOUT_VALID, output, 1: result available.
REQ-012 Port DOUT_READY, input, 1: consumer accepts the result.
REQ-013 Port OVR, output, 1: one-cycle pulse on a START that is dropped.

Function
REQ-014 FSM states SHALL be exactly IDLE, SAMPLE, CONVERT and VALID.
REQ-015 IDLE: START=1 at an edge -> SAMPLE; the sample counter loads SAMPLE_CYCLES-1 and SH=1.
REQ-016 SAMPLE: the counter decrements each edge; at an edge with counter=0 -> CONVERT, with SH=0 and DAC_CODE = 1<<(NBITS-1).
REQ-017 CONVERT: each edge resolves the current trial bit b (starting at MSB): keep bit b if CMP=1, clear it if CMP=0, and set bit b-1 in DAC_CODE if b>0.
REQ-018 CONVERT: the edge that resolves bit 0 SHALL load DOUT with the final code, set DOUT_VALID=1 and go to VALID.
REQ-019 Latency: START sampled at edge E0 -> DOUT_VALID high after edge E0+SAMPLE_CYCLES+NBITS (14 edges at default parameters).
REQ-020 VALID: DOUT and DOUT_VALID SHALL hold stable until an edge with DOUT_READY=1.
REQ-021 VALID, DOUT_READY=1 and START=0 at the same edge -> IDLE, DOUT_VALID=0.
REQ-022 VALID, DOUT_READY=1 and START=1 at the same edge -> SAMPLE directly (back-to-back conversion), DOUT_VALID=0.
REQ-023 START=1 in SAMPLE or CONVERT, or in VALID with DOUT_READY=0, SHALL be ignored and SHALL pulse OVR for exactly that one cycle; the conversion in progress is unaffected.
REQ-024 DAC_CODE SHALL hold its last value in IDLE and VALID; DOUT SHALL hold its last result outside VALID.
REQ-025 SH SHALL be 0 in every state except SAMPLE.
REQ-026 The bit index counter SHALL be ceil(log2(NBITS)) bits wide, with no wrap beyond bit 0.
REQ-027 DOUT_READY outside VALID SHALL be ignored.

Reset
REQ-028 RSTN=0 SHALL asynchronously force: state IDLE, SH=0, DAC_CODE=0, DOUT=0, DOUT_VALID=0, BUSY=0, OVR=0, all counters 0.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion without producing DOUT_VALID.
REQ-030 After RSTN deasserts, the first START SHALL be honored on the first rising edge of CK.

Structure
REQ-031 A shared package adc_pkg SHALL hold the state enum typedef and the NBITS default constant, reused by the ADC/DAC models.
REQ-032 The block SHALL be a single module with no sub-modules; the FSM, sample counter, bit counter and SAR register are all local.

Verification
REQ-033 Behavioral comparator CMP=(0x9A5 >= DAC_CODE), one START pulse -> DOUT=0x9A5, DOUT_VALID high 14 cycles after START, SH high for exactly 2 cycles.
REQ-034 CMP tied to 1 -> DOUT=0xFFF; CMP tied to 0 -> DOUT=0x000; the DAC_CODE trial sequence in each case matches the SAR algorithm bit-by-bit.
REQ-035 DOUT_READY held low for 20 cycles after DOUT_VALID -> DOUT stable throughout; START pulses during this window each give a one-cycle OVR and no new conversion.
REQ-036 START and DOUT_READY asserted together in VALID -> SH=1 on the next cycle, second result correct (target 0x123), no IDLE cycle between conversions.
REQ-037 RSTN pulsed low during CONVERT bit 5 -> all outputs 0 immediately, no DOUT_VALID; a following START gives a correct result (target 0x800 -> DOUT=0x800).
